// File: rtl/clp_instr_responder.sv
// Responder side of the CLP enable/instruction/state handshake; expands one instruction into address commands.
// Optional build macro CLP_RESP_PERF_CNT_EN adds the instr_cnt/stall_cnt performance counters.
module clp_instr_responder #(
  parameter int unsigned INSTR_W  = 100,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned MIN_BUSY = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [INSTR_W-1:0] instruction,
  output logic               state,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [3:0]         cmd_op,
  output logic [ADDR_W-1:0]  cmd_in_addr,
  output logic [ADDR_W-1:0]  cmd_w_addr,
  output logic [ADDR_W-1:0]  cmd_out_addr,
  output logic               cmd_last,
  output logic               err
`ifdef CLP_RESP_PERF_CNT_EN
  ,
  output logic [31:0]        instr_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_RUN,
    S_DONE
  } fsm_t;

  localparam logic [3:0]  OP_NOP  = 4'd0;
  localparam logic [3:0]  OP_POOL = 4'd2;
  localparam logic [31:0] BUSY_M1 = 32'(MIN_BUSY - 1);

  fsm_t              fsm;
  logic              armed;
  logic [ADDR_W-1:0] in_base_q;
  logic [ADDR_W-1:0] out_base_q;
  logic [ADDR_W-1:0] w_base_q;
  logic [7:0]        rows_q;
  logic [7:0]        cols_q;
  logic [7:0]        chans_q;
  logic [7:0]        col_q;
  logic [7:0]        row_q;
  logic [7:0]        chan_q;
  logic [31:0]       busy_cnt;

  logic              accept;
  logic              handshake;
  logic              illegal_op;
  logic              empty_job;
  logic              col_wrap;
  logic              row_wrap;
  logic [7:0]        nxt_col;
  logic [7:0]        nxt_row;
  logic [7:0]        nxt_chan;
  logic              nxt_last;
  logic              unused_rsvd;

  assign unused_rsvd = &{1'b0, instruction[23:0]};

  assign accept     = (fsm == S_IDLE) && enable && armed;
  assign handshake  = cmd_valid && cmd_ready;
  assign illegal_op = cmd_op > OP_POOL;
  assign empty_job  = (cmd_op == OP_NOP) || (rows_q == '0) || (cols_q == '0) || (chans_q == '0);

  // Next loop indices for the col (inner) / row / chan (outer) nest, plus the look-ahead last flag.
  always_comb begin
    col_wrap = (col_q == cols_q - 8'd1);
    row_wrap = (row_q == rows_q - 8'd1);
    nxt_col  = col_wrap ? '0 : col_q + 8'd1;
    nxt_row  = row_q;
    nxt_chan = chan_q;
    if (col_wrap) begin
      nxt_row = row_wrap ? '0 : row_q + 8'd1;
      if (row_wrap) nxt_chan = chan_q + 8'd1;
    end
    nxt_last = (nxt_chan == chans_q - 8'd1) && (nxt_row == rows_q - 8'd1) &&
               (nxt_col == cols_q - 8'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm          <= S_IDLE;
      armed        <= 1'b1;
      state        <= 1'b0;
      cmd_valid    <= 1'b0;
      cmd_last     <= 1'b0;
      cmd_op       <= '0;
      cmd_in_addr  <= '0;
      cmd_w_addr   <= '0;
      cmd_out_addr <= '0;
      err          <= 1'b0;
      in_base_q    <= '0;
      out_base_q   <= '0;
      w_base_q     <= '0;
      rows_q       <= '0;
      cols_q       <= '0;
      chans_q      <= '0;
      col_q        <= '0;
      row_q        <= '0;
      chan_q       <= '0;
      busy_cnt     <= '0;
    end else begin
      if (!enable) armed <= 1'b1;
      if (fsm != S_IDLE && busy_cnt != '1) busy_cnt <= busy_cnt + 32'd1;

      case (fsm)
        S_IDLE: begin
          if (accept) begin
            cmd_op     <= instruction[99:96];
            in_base_q  <= ADDR_W'(instruction[95:80]);
            out_base_q <= ADDR_W'(instruction[79:64]);
            w_base_q   <= ADDR_W'(instruction[63:48]);
            rows_q     <= instruction[47:40];
            cols_q     <= instruction[39:32];
            chans_q    <= instruction[31:24];
            armed      <= 1'b0;
            err        <= 1'b0;
            state      <= 1'b1;
            busy_cnt   <= '0;
            fsm        <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (illegal_op) begin
            err <= 1'b1;
            fsm <= S_DONE;
          end else if (empty_job) begin
            fsm <= S_DONE;
          end else begin
            col_q        <= '0;
            row_q        <= '0;
            chan_q       <= '0;
            cmd_in_addr  <= in_base_q;
            cmd_w_addr   <= w_base_q;
            cmd_out_addr <= out_base_q;
            cmd_valid    <= 1'b1;
            cmd_last     <= (rows_q == 8'd1) && (cols_q == 8'd1) && (chans_q == 8'd1);
            fsm          <= S_RUN;
          end
        end
        S_RUN: begin
          if (handshake) begin
            if (cmd_last) begin
              cmd_valid <= 1'b0;
              cmd_last  <= 1'b0;
              fsm       <= S_DONE;
            end else begin
              col_q        <= nxt_col;
              row_q        <= nxt_row;
              chan_q       <= nxt_chan;
              cmd_last     <= nxt_last;
              cmd_out_addr <= cmd_out_addr + 1'b1;
              // The input pointer restarts at in_base whenever a new channel begins.
              if (col_wrap && row_wrap) begin
                cmd_in_addr <= in_base_q;
                cmd_w_addr  <= w_base_q + ADDR_W'(nxt_chan);
              end else begin
                cmd_in_addr <= cmd_in_addr + 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          // busy_cnt counts busy cycles already completed, so this DONE cycle makes busy_cnt+1.
          if (busy_cnt >= BUSY_M1) begin
            state <= 1'b0;
            fsm   <= S_IDLE;
          end
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

`ifdef CLP_RESP_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept && instr_cnt != '1) instr_cnt <= instr_cnt + 32'd1;
      if (cmd_valid && !cmd_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
